// File: rtl/io_cond_pkg.sv
// Shared constants and types for the board I/O conditioning blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package io_cond_pkg;

    // 10 ms of hold time at a 100 MHz core clock.
    localparam int DEBOUNCE_10MS_100MHZ = 1000000;

    // Short hold time so simulations finish quickly.
    localparam int DEBOUNCE_SIM = 4;

    // Channel filter mode: idle while the synchronised input agrees with the
    // published level, counting while it disagrees.
    typedef enum logic [0:0] {
        DB_IDLE  = 1'b0,
        DB_COUNT = 1'b1
    } db_state_e;

endpackage

// File: rtl/debounce_chan.sv
// One switch channel: 2-flop synchroniser, stability counter, level, edge pulses, toggle.
// Latency: a change sampled at edge k is published after edge k+1+STABLE_CYCLES; toggle one edge later.
// Backpressure: none; level input, free-running outputs with no flow control.
module debounce_chan
    import io_cond_pkg::*;
#(
    parameter int STABLE_CYCLES = DEBOUNCE_10MS_100MHZ
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic state,
    output logic rise,
    output logic fall,
    output logic toggle
);

    localparam int CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    // A hold time below two cycles cannot be represented by the counter.
    if (STABLE_CYCLES < 2) begin : g_bad_stable_cycles
        $fatal(1, "debounce_chan: STABLE_CYCLES must be >= 2");
    end

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             state_nxt;
    logic             rise_nxt;
    logic             fall_nxt;
    db_state_e        mode;

    // Two-flop synchroniser; only s2 is trusted downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Filter decision: count while s2 disagrees, accept on the final count.
    always_comb begin
        cnt_nxt   = '0;
        state_nxt = state;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        mode      = (s2 != state) ? DB_COUNT : DB_IDLE;
        case (mode)
            DB_IDLE: begin
                cnt_nxt = '0;
            end
            DB_COUNT: begin
                if (cnt == CNT_MAX) begin
                    // Counter saturates here and restarts; it never wraps.
                    cnt_nxt   = '0;
                    state_nxt = s2;
                    rise_nxt  = s2;
                    fall_nxt  = ~s2;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                cnt_nxt = '0;
            end
        endcase
    end

    // Counter, published level and edge pulses share one register stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            state <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            cnt   <= cnt_nxt;
            state <= state_nxt;
            rise  <= rise_nxt;
            fall  <= fall_nxt;
        end
    end

    // Toggle latch flips on the edge after a rise pulse; falls are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            toggle <= 1'b0;
        end else begin
            toggle <= toggle ^ rise;
        end
    end

endmodule

// File: rtl/sw_debounce.sv
// Debounces N asynchronous switch inputs into clean levels, edge pulses and toggle latches.
// Latency: STABLE_CYCLES+2 edges from first sample of a clean change to sw_state/sw_rise/sw_fall.
// Backpressure: none; sw_any is a combinational OR of the registered pulses.
module sw_debounce
    import io_cond_pkg::*;
#(
    parameter int N             = 2,
    parameter int STABLE_CYCLES = DEBOUNCE_10MS_100MHZ
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] sw_raw,
    output logic [N-1:0] sw_state,
    output logic [N-1:0] sw_rise,
    output logic [N-1:0] sw_fall,
    output logic [N-1:0] sw_toggle,
    output logic         sw_any
);

    // One independent filter per switch channel.
    for (genvar i = 0; i < N; i++) begin : g_chan
        debounce_chan #(
            .STABLE_CYCLES (STABLE_CYCLES)
        ) u_chan (
            .clk    (clk),
            .rst_n  (rst_n),
            .raw    (sw_raw[i]),
            .state  (sw_state[i]),
            .rise   (sw_rise[i]),
            .fall   (sw_fall[i]),
            .toggle (sw_toggle[i])
        );
    end

    // Simultaneous changes on several channels collapse into one event pulse.
    assign sw_any = |(sw_rise | sw_fall);

endmodule

// File: tb/tb_sw_debounce.sv
module tb_sw_debounce;
    import io_cond_pkg::*;

    localparam int N  = 2;
    localparam int SC = DEBOUNCE_SIM;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] sw_raw;
    logic [N-1:0] sw_state;
    logic [N-1:0] sw_rise;
    logic [N-1:0] sw_fall;
    logic [N-1:0] sw_toggle;
    logic         sw_any;

    sw_debounce #(
        .N             (N),
        .STABLE_CYCLES (SC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw_raw    (sw_raw),
        .sw_state  (sw_state),
        .sw_rise   (sw_rise),
        .sw_fall   (sw_fall),
        .sw_toggle (sw_toggle),
        .sw_any    (sw_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Number of rising edges seen so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           at;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
        logic [N-1:0] state;
        logic [N-1:0] tog;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int at, input logic [N-1:0] r, input logic [N-1:0] f,
                            input logic [N-1:0] s, input logic [N-1:0] t);
        exp_t e;
        e.at = at; e.rise = r; e.fall = f; e.state = s; e.tog = t;
        sb.push_back(e);
    endtask

    // Drive sw_raw on a falling edge and report the edge count at that moment.
    task automatic drive(input logic [N-1:0] v, output int c);
        @(negedge clk);
        sw_raw = v;
        c = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_state"},  32'(sw_state),  32'h0);
        chk({tag, "_rise"},   32'(sw_rise),   32'h0);
        chk({tag, "_fall"},   32'(sw_fall),   32'h0);
        chk({tag, "_toggle"}, 32'(sw_toggle), 32'h0);
        chk({tag, "_any"},    32'(sw_any),    32'h0);
    endtask

    task automatic check_drained(input string tag);
        chk({tag, "_pending_events"}, 32'(sb.size()), 32'h0);
        sb.delete();
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        sw_raw = '0;
        idle(3);
        rst_n = 1'b1;
    endtask

    // Monitor: every pulse cycle pops one expected event; toggle checked one cycle later.
    logic         tog_pend = 1'b0;
    logic [N-1:0] tog_exp  = '0;
    always @(negedge clk) begin
        exp_t e;
        if (tog_pend) begin
            chk("toggle_after_pulse", 32'(sw_toggle), 32'(tog_exp));
            tog_pend = 1'b0;
        end
        if ((sw_rise | sw_fall) != '0 || sw_any) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: rise=%b fall=%b any=%b expected no pulse (cycle %0d)",
                         sw_rise, sw_fall, sw_any, cyc);
            end else begin
                e = sb.pop_front();
                chk("pulse_cycle", 32'(cyc), 32'(e.at));
                chk("pulse_rise", 32'(sw_rise), 32'(e.rise));
                chk("pulse_fall", 32'(sw_fall), 32'(e.fall));
                chk("pulse_state", 32'(sw_state), 32'(e.state));
                chk("pulse_any", 32'(sw_any), 32'h1);
                chk("pulse_rise_fall_excl", 32'(sw_rise & sw_fall), 32'h0);
                tog_pend = 1'b1;
                tog_exp  = e.tog;
            end
        end
    end

    initial begin
        int c;
        int r;
        rst_n  = 1'b0;
        sw_raw = '0;

        // Reset holds everything at zero.
        idle(3);
        #1;
        check_zero("in_reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle(20);
        check_zero("idle_after_reset");
        check_drained("idle");

        // Single clean rise on channel 0.
        drive(2'b01, c);
        push_exp(c + 6, 2'b01, 2'b00, 2'b01, 2'b01);
        idle(10);
        chk("ch0_rise_state", 32'(sw_state), 32'h1);
        check_drained("ch0_rise");

        // Return channel 0 low, then bounce it (never stable for 4 cycles).
        drive(2'b00, c);
        push_exp(c + 6, 2'b00, 2'b01, 2'b00, 2'b01);
        idle(10);
        check_drained("ch0_fall");
        @(negedge clk);
        repeat (5) begin
            sw_raw = 2'b01;
            idle(3);
            sw_raw = 2'b00;
            idle(1);
        end
        idle(12);
        chk("bounce_state", 32'(sw_state), 32'h0);
        chk("bounce_toggle", 32'(sw_toggle), 32'h1);
        check_drained("bounce");

        // Both channels together from a fresh reset.
        pulse_reset();
        idle(2);
        drive(2'b11, c);
        push_exp(c + 6, 2'b11, 2'b00, 2'b11, 2'b11);
        idle(10);
        drive(2'b00, c);
        push_exp(c + 6, 2'b00, 2'b11, 2'b00, 2'b11);
        idle(10);
        chk("both_fall_toggle_kept", 32'(sw_toggle), 32'h3);
        check_drained("both");

        // Two press/release cycles on channel 1 from a fresh reset.
        pulse_reset();
        idle(2);
        drive(2'b10, c);
        push_exp(c + 6, 2'b10, 2'b00, 2'b10, 2'b10);
        idle(10);
        drive(2'b00, c);
        push_exp(c + 6, 2'b00, 2'b10, 2'b00, 2'b10);
        idle(10);
        drive(2'b10, c);
        push_exp(c + 6, 2'b10, 2'b00, 2'b10, 2'b00);
        idle(10);
        drive(2'b00, c);
        push_exp(c + 6, 2'b00, 2'b10, 2'b00, 2'b00);
        idle(10);
        check_drained("ch1_twice");

        // Reset while channel 0 is counting down from a high level.
        drive(2'b01, c);
        push_exp(c + 6, 2'b01, 2'b00, 2'b01, 2'b01);
        idle(10);
        check_drained("pre_mid_reset");
        drive(2'b00, c);
        idle(4);
        chk("mid_count_state_held", 32'(sw_state), 32'h1);
        #1;
        rst_n  = 1'b0;
        sw_raw = 2'b01;
        #1;
        check_zero("async_reset");
        idle(3);
        rst_n = 1'b1;
        r = cyc;
        push_exp(r + 6, 2'b01, 2'b00, 2'b01, 2'b01);
        idle(12);
        chk("post_reset_state", 32'(sw_state), 32'h1);
        check_drained("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
